// File: rtl/intr_request_ctrl_pkg.sv
// Shared constants and helpers for the interrupt request controller.
// Source bit order everywhere is {C,B,A}, so bit index = priority.
package intr_pkg;

  localparam int NUM_SRC = 3;

  localparam logic [1:0] INT_NO_NONE = 2'd0;
  localparam logic [1:0] INT_NO_A    = 2'd1;
  localparam logic [1:0] INT_NO_B    = 2'd2;
  localparam logic [1:0] INT_NO_C    = 2'd3;

  function automatic logic [NUM_SRC-1:0] no2onehot(input logic [1:0] no);
    logic [NUM_SRC-1:0] oh;
    oh = '0;
    case (no)
      INT_NO_A: oh = 3'b001;
      INT_NO_B: oh = 3'b010;
      INT_NO_C: oh = 3'b100;
      default:  oh = '0;
    endcase
    return oh;
  endfunction

  function automatic logic [NUM_SRC-1:0] highest_set(input logic [NUM_SRC-1:0] v);
    logic [NUM_SRC-1:0] oh;
    oh = '0;
    if (v[2])      oh = 3'b100;
    else if (v[1]) oh = 3'b010;
    else if (v[0]) oh = 3'b001;
    return oh;
  endfunction

endpackage

// File: rtl/intr_request_ctrl_if.sv
// CPU-side bundle: ack/eret from the handler, masked requests and status back.
interface intr_request_ctrl_if;
  import intr_pkg::*;

  logic               int_ack;
  logic [1:0]         ack_no;
  logic               int_eret;
  logic               IRA;
  logic               IRB;
  logic               IRC;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] in_service;

  modport master (
    output int_ack, ack_no, int_eret,
    input  IRA, IRB, IRC, pending, in_service
  );

  modport slave (
    input  int_ack, ack_no, int_eret,
    output IRA, IRB, IRC, pending, in_service
  );

endinterface

// File: rtl/intr_request_ctrl_debounce.sv
// Synchroniser + debouncer for one raw button; rise pulses for one cycle
// in the cycle after the debounced level goes 0->1.
module irq_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level,
  output logic rise
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic                   level_q, level_d;
  logic                   level_dly_q;
  logic                   synced;

  assign synced  = sync_q[SYNC_STAGES-1];
  assign cnt_inc = cnt_q + CNT_ONE;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw_in};
    level_d = level_q;
    cnt_d   = '0;
    // Counter only runs while the synced value disagrees with the level
    if (synced != level_q) begin
      if (cnt_inc == CNT_MAX) level_d = ~level_q;
      else                    cnt_d   = cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
    end
  end

  assign level = level_q;
  assign rise  = level_q & ~level_dly_q;

endmodule

// File: rtl/intr_request_ctrl.sv
// Debounces three buttons, latches rising edges as pending, tracks in-service
// levels and masks requests so only strictly higher priority may nest.
module intr_request_ctrl
  import intr_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int NESTED          = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                irq_a_raw,
  input  logic                irq_b_raw,
  input  logic                irq_c_raw,
  intr_request_ctrl_if.slave  cpu
);

  logic [NUM_SRC-1:0] raw, lvl, rise;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] in_service_q, in_service_d;
  logic [NUM_SRC-1:0] ack_oh, blocked, req;

  assign raw = {irq_c_raw, irq_b_raw, irq_a_raw};

  irq_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbc_a (
    .clk(clk), .rst(rst), .raw_in(raw[0]), .level(lvl[0]), .rise(rise[0]));
  irq_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbc_b (
    .clk(clk), .rst(rst), .raw_in(raw[1]), .level(lvl[1]), .rise(rise[1]));
  irq_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbc_c (
    .clk(clk), .rst(rst), .raw_in(raw[2]), .level(lvl[2]), .rise(rise[2]));

  a_rise_implies_level: assert property (@(posedge clk) disable iff (rst) (rise & ~lvl) == '0);

  assign ack_oh = cpu.int_ack ? no2onehot(cpu.ack_no) : '0;

  always_comb begin
    // A fresh rise wins over a same-cycle ack of that source
    pending_d    = (pending_q & ~ack_oh) | rise;
    in_service_d = in_service_q;
    if (cpu.int_eret) in_service_d = in_service_d & ~highest_set(in_service_d);
    in_service_d = in_service_d | ack_oh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= '0;
      in_service_q <= '0;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
    end
  end

  generate
    if (NESTED != 0) begin : g_nested
      assign blocked = {in_service_q[2], |in_service_q[2:1], |in_service_q};
    end else begin : g_flat
      assign blocked = {NUM_SRC{|in_service_q}};
    end
  endgenerate

  assign req            = pending_q & ~blocked;
  assign cpu.IRA        = req[0];
  assign cpu.IRB        = req[1];
  assign cpu.IRC        = req[2];
  assign cpu.pending    = pending_q;
  assign cpu.in_service = in_service_q;

endmodule

// File: tb/tb_intr_request_ctrl.sv
// Bench for intr_request_ctrl: NESTED=1 and NESTED=0 instances share stimulus.
module tb_intr_request_ctrl;
  import intr_pkg::*;

  localparam int S  = 2;
  localparam int D  = 4;
  localparam int HL = S + D - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] raw = 3'b000;
  logic       ack = 1'b0;
  logic [1:0] ack_no = 2'd0;
  logic       eret = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  intr_request_ctrl_if bus_n ();
  intr_request_ctrl_if bus_f ();

  assign bus_n.int_ack  = ack;
  assign bus_n.ack_no   = ack_no;
  assign bus_n.int_eret = eret;
  assign bus_f.int_ack  = ack;
  assign bus_f.ack_no   = ack_no;
  assign bus_f.int_eret = eret;

  intr_request_ctrl #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .NESTED(1)) dut_n (
    .clk(clk), .rst(rst), .irq_a_raw(raw[0]), .irq_b_raw(raw[1]), .irq_c_raw(raw[2]),
    .cpu(bus_n));
  intr_request_ctrl #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .NESTED(0)) dut_f (
    .clk(clk), .rst(rst), .irq_a_raw(raw[0]), .irq_b_raw(raw[1]), .irq_c_raw(raw[2]),
    .cpu(bus_f));

  // Reference model: a source's level flips once the last D synchronised samples
  // all disagree with it; sample seen at edge e is the raw value from edge e-S.
  bit         hist [3][$];
  bit         m_lvl [3];
  bit         m_lvl_old [3];
  bit [2:0]   m_pend;
  bit [2:0]   m_is;

  always @(posedge clk) begin
    bit [2:0] rise_v;
    bit [2:0] ackv;
    bit       all_diff;
    if (rst) begin
      for (int s = 0; s < 3; s++) begin
        hist[s].delete();
        for (int j = 0; j < HL; j++) hist[s].push_back(1'b0);
        m_lvl[s]     = 1'b0;
        m_lvl_old[s] = 1'b0;
      end
      m_pend = '0;
      m_is   = '0;
    end else begin
      rise_v = '0;
      for (int s = 0; s < 3; s++) begin
        rise_v[s] = m_lvl[s] & ~m_lvl_old[s];
        all_diff = 1'b1;
        for (int j = 0; j < D; j++) if (hist[s][j] == m_lvl[s]) all_diff = 1'b0;
        m_lvl_old[s] = m_lvl[s];
        if (all_diff) m_lvl[s] = ~m_lvl[s];
        hist[s].push_back(raw[s]);
        void'(hist[s].pop_front());
      end
      ackv = '0;
      if (ack && ack_no != 2'd0) ackv[int'(ack_no) - 1] = 1'b1;
      m_pend = (m_pend & ~ackv) | rise_v;
      if (eret) begin
        for (int p = 2; p >= 0; p--) begin
          if (m_is[p]) begin
            m_is[p] = 1'b0;
            break;
          end
        end
      end
      m_is = m_is | ackv;
    end
  end

  // A source may request only if no in-service source is at its own priority or above
  // (nested), or nothing is in service at all (flat).
  function automatic bit [2:0] exp_ir(bit [2:0] pend, bit [2:0] is, bit nested);
    bit [2:0] r;
    bit       blk;
    for (int s = 0; s < 3; s++) begin
      blk = 1'b0;
      for (int p = 0; p < 3; p++) if (is[p] && (!nested || p >= s)) blk = 1'b1;
      r[s] = pend[s] && !blk;
    end
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; raw = '0; ack = 1'b0; ack_no = 2'd0; eret = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  task automatic press(input int s);
    raw[s] = 1'b1;
    repeat (S + D + 1) cyc();
    raw[s] = 1'b0;
    repeat (S + D + 1) cyc();
  endtask

  task automatic ack_src(input logic [1:0] no);
    ack = 1'b1; ack_no = no;
    cyc();
    ack = 1'b0; ack_no = 2'd0;
  endtask

  task automatic eret_pulse();
    eret = 1'b1;
    cyc();
    eret = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; raw = 3'b111; ack = 1'b0; eret = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_tests++;
      if ({bus_n.IRC, bus_n.IRB, bus_n.IRA, bus_n.pending, bus_n.in_service} !== 9'd0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: IR=%b pend=%b is=%b, want all 0", i,
                 {bus_n.IRC, bus_n.IRB, bus_n.IRA}, bus_n.pending, bus_n.in_service);
      end
    end
    rst = 1'b0;
    repeat (S + D) cyc();
    n_tests++;
    if (bus_n.pending !== 3'b000) begin
      n_fail++; $display("FAIL reset_early pending=%b want 000", bus_n.pending);
    end
    cyc();
    n_tests++;
    if (bus_n.pending !== 3'b111 || {bus_n.IRC, bus_n.IRB, bus_n.IRA} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_latency pending=%b IR=%b want 111/111", bus_n.pending,
               {bus_n.IRC, bus_n.IRB, bus_n.IRA});
    end
  endtask

  task automatic test_glitch();
    do_reset();
    raw[0] = 1'b1;
    repeat (D - 1) cyc();
    raw[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_tests++;
      if (bus_n.pending !== 3'b000) begin
        n_fail++; $display("FAIL glitch_short cycle %0d pending=%b want 000", i, bus_n.pending);
      end
    end
    raw[0] = 1'b1;
    repeat (S + D) cyc();
    raw[0] = 1'b0;
    n_tests++;
    if (bus_n.pending[0] !== 1'b0) begin
      n_fail++; $display("FAIL glitch_long_early pending[0]=%b want 0", bus_n.pending[0]);
    end
    cyc();
    n_tests++;
    if (bus_n.pending !== 3'b001 || bus_n.IRA !== 1'b1) begin
      n_fail++; $display("FAIL glitch_long pending=%b IRA=%b want 001/1", bus_n.pending, bus_n.IRA);
    end
  endtask

  task automatic test_ack_eret();
    ack_src(INT_NO_A);
    n_tests++;
    if (bus_n.pending !== 3'b000 || bus_n.in_service !== 3'b001 || bus_n.IRA !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_a pending=%b is=%b IRA=%b want 000/001/0", bus_n.pending,
               bus_n.in_service, bus_n.IRA);
    end
    eret_pulse();
    n_tests++;
    if (bus_n.in_service !== 3'b000) begin
      n_fail++; $display("FAIL eret_a is=%b want 000", bus_n.in_service);
    end
  endtask

  task automatic test_nesting();
    do_reset();
    press(0);
    ack_src(INT_NO_A);
    press(1);
    n_tests++;
    if (bus_n.IRB !== 1'b1 || bus_f.IRB !== 1'b0) begin
      n_fail++; $display("FAIL nest_b IRB nested=%b flat=%b want 1/0", bus_n.IRB, bus_f.IRB);
    end
    ack_src(INT_NO_B);
    n_tests++;
    if (bus_n.in_service !== 3'b011) begin
      n_fail++; $display("FAIL nest_ack_b is=%b want 011", bus_n.in_service);
    end
    press(0);
    n_tests++;
    if (bus_n.pending[0] !== 1'b1 || bus_n.IRA !== 1'b0) begin
      n_fail++; $display("FAIL nest_a_blocked pend[0]=%b IRA=%b want 1/0", bus_n.pending[0], bus_n.IRA);
    end
    eret_pulse();
    n_tests++;
    if (bus_n.in_service !== 3'b001 || bus_n.IRA !== 1'b0) begin
      n_fail++; $display("FAIL nest_eret1 is=%b IRA=%b want 001/0", bus_n.in_service, bus_n.IRA);
    end
    eret_pulse();
    n_tests++;
    if (bus_n.in_service !== 3'b000 || bus_n.IRA !== 1'b1) begin
      n_fail++; $display("FAIL nest_eret2 is=%b IRA=%b want 000/1", bus_n.in_service, bus_n.IRA);
    end
  endtask

  task automatic test_lower_blocked();
    do_reset();
    press(2);
    ack_src(INT_NO_C);
    press(1);
    n_tests++;
    if (bus_n.pending[1] !== 1'b1 || bus_n.IRB !== 1'b0) begin
      n_fail++; $display("FAIL lower_b pend[1]=%b IRB=%b want 1/0", bus_n.pending[1], bus_n.IRB);
    end
    eret_pulse();
    n_tests++;
    if (bus_n.IRB !== 1'b1) begin
      n_fail++; $display("FAIL lower_b_eret IRB=%b want 1", bus_n.IRB);
    end
    do_reset();
    press(0);
    ack_src(INT_NO_A);
    press(2);
    n_tests++;
    if (bus_f.IRC !== 1'b0 || bus_n.IRC !== 1'b1) begin
      n_fail++; $display("FAIL flat_c IRC flat=%b nested=%b want 0/1", bus_f.IRC, bus_n.IRC);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    press(1);
    raw[1] = 1'b1;
    repeat (S + D) cyc();
    ack = 1'b1; ack_no = INT_NO_B;
    cyc();
    ack = 1'b0; ack_no = 2'd0; raw[1] = 1'b0;
    n_tests++;
    if (bus_n.pending[1] !== 1'b1 || bus_n.in_service !== 3'b010) begin
      n_fail++;
      $display("FAIL sim_rise_ack pend[1]=%b is=%b want 1/010", bus_n.pending[1], bus_n.in_service);
    end
    press(2);
    eret = 1'b1; ack = 1'b1; ack_no = INT_NO_C;
    cyc();
    eret = 1'b0; ack = 1'b0; ack_no = 2'd0;
    n_tests++;
    if (bus_n.in_service !== 3'b100 || bus_n.pending !== 3'b010) begin
      n_fail++;
      $display("FAIL sim_eret_ack is=%b pend=%b want 100/010", bus_n.in_service, bus_n.pending);
    end
    ack_src(INT_NO_NONE);
    n_tests++;
    if (bus_n.in_service !== 3'b100 || bus_n.pending !== 3'b010) begin
      n_fail++;
      $display("FAIL ack_none is=%b pend=%b want 100/010", bus_n.in_service, bus_n.pending);
    end
  endtask

  task automatic test_random();
    int s;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 3; k++) if ($urandom_range(0, 9) == 0) raw[k] = ~raw[k];
      ack = 1'b0; ack_no = 2'd0; eret = 1'b0;
      if ($urandom_range(0, 5) == 0) begin
        s = $urandom_range(0, 2);
        ack = 1'b1;
        ack_no = m_pend[s] ? 2'(s + 1) : INT_NO_NONE;
      end
      if ($urandom_range(0, 7) == 0) eret = 1'b1;
      cyc();
      n_tests++;
      if (bus_n.pending !== m_pend || bus_f.pending !== m_pend) begin
        n_fail++;
        $display("FAIL rand_pending c=%0d got=%b/%b want=%b", c, bus_n.pending, bus_f.pending, m_pend);
      end
      n_tests++;
      if (bus_n.in_service !== m_is || bus_f.in_service !== m_is) begin
        n_fail++;
        $display("FAIL rand_is c=%0d got=%b/%b want=%b", c, bus_n.in_service, bus_f.in_service, m_is);
      end
      n_tests++;
      if ({bus_n.IRC, bus_n.IRB, bus_n.IRA} !== exp_ir(m_pend, m_is, 1'b1)) begin
        n_fail++;
        $display("FAIL rand_ir_nested c=%0d got=%b want=%b", c,
                 {bus_n.IRC, bus_n.IRB, bus_n.IRA}, exp_ir(m_pend, m_is, 1'b1));
      end
      n_tests++;
      if ({bus_f.IRC, bus_f.IRB, bus_f.IRA} !== exp_ir(m_pend, m_is, 1'b0)) begin
        n_fail++;
        $display("FAIL rand_ir_flat c=%0d got=%b want=%b", c,
                 {bus_f.IRC, bus_f.IRB, bus_f.IRA}, exp_ir(m_pend, m_is, 1'b0));
      end
    end
    ack = 1'b0; ack_no = 2'd0; eret = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_ack_eret();
    test_nesting();
    test_lower_blocked();
    test_simultaneous();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
